ram_sp_clr: RTL

Parametrised single-port synchronous RAM. It is the successor to the fixed 4K x 16 RAM.
- Adds configurable width and depth.
- Adds a registered read with a valid strobe.
- Adds a selectable read-during-write mode.
- Adds a hardware clear sequencer that zero-fills every location after reset.
- Used as a general scratch/data memory by the datapath and the lab CPU blocks.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_sp_clr_if.sv | 30 +++
 rtl/ram_clr_seq.sv | 62 ++++++
 rtl/ram_sp_clr.sv | 104 ++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port clearing RAM.
// Optional word parity is enabled with the RAM_PARITY_EN macro.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  // Widest word the parity helper accepts; callers zero-extend.
  localparam int unsigned PAR_MAX_W = 64;

  function automatic logic parity_f(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_sp_clr_if.sv
// Request/response bundle of the single-port clearing RAM.
// RAM_PARITY_EN adds the par_err response bit.
interface ram_sp_clr_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) ();

  logic              en;
  logic              w;
  logic              r;
  logic [ADDR_W-1:0] add;
  logic [DATA_W-1:0] d_in;
  logic [DATA_W-1:0] d_out;
  logic              valid;
  logic              busy;
`ifdef RAM_PARITY_EN
  logic              par_err;

  modport master (output en, w, r, add, d_in,
                  input  d_out, valid, busy, par_err);
  modport slave  (input  en, w, r, add, d_in,
                  output d_out, valid, busy, par_err);
`else
  modport master (output en, w, r, add, d_in,
                  input  d_out, valid, busy);
  modport slave  (input  en, w, r, add, d_in,
                  output d_out, valid, busy);
`endif

endinterface

// File: rtl/ram_clr_seq.sv
// Post-reset zero-fill sequencer and write-port mux for the RAM array.
// Owns the CLEAR/READY state, the clear address and busy.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              w,
  input  logic [ADDR_W-1:0] add,
  input  logic [DATA_W-1:0] d_in,
  output logic              busy,
  output logic              in_range_c,
  output logic              mem_we_c,
  output logic [ADDR_W-1:0] mem_addr_c,
  output logic [DATA_W-1:0] mem_wdata_c
);

  // One extra bit so DEPTH == 2**ADDR_W does not truncate.
  localparam int unsigned AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0] DEPTH_X = AW1'(DEPTH);
  localparam logic [AW1-1:0] LAST_X  = AW1'(DEPTH - 1);

  state_e            state;
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else if (state == CLEAR) begin
      if ({1'b0, clr_addr} == LAST_X) begin
        state    <= READY;
        busy     <= 1'b0;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + ADDR_W'(1);
      end
    end
  end

  // Clear owns the write port; user writes only land in range once READY.
  always_comb begin
    in_range_c  = ({1'b0, add} < DEPTH_X);
    mem_we_c    = 1'b0;
    mem_addr_c  = add;
    mem_wdata_c = d_in;
    if (state == CLEAR) begin
      mem_we_c    = 1'b1;
      mem_addr_c  = clr_addr;
      mem_wdata_c = '0;
    end else begin
      mem_we_c    = en & w & in_range_c;
    end
  end

endmodule

// File: rtl/ram_sp_clr.sv
// Parametrised single-port RAM with registered read, valid strobe,
// selectable read-during-write and post-reset zero fill. Macro: RAM_PARITY_EN.
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned RD_MODE = RD_FIRST
) (
  input  logic         clk,
  input  logic         rst,
  ram_sp_clr_if.slave  bus
);

`ifdef RAM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif
  localparam bit WR_FWD = (RD_MODE == WR_FIRST);

  logic              busy;
  logic              in_range_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [MEM_W-1:0]  wr_word_c;
  logic [MEM_W-1:0]  rd_word_c;
  logic              rd_req_c;
  logic [DATA_W-1:0] d_out_q;
  logic              valid_q;

  logic [MEM_W-1:0]  mem [DEPTH];

  ram_clr_seq #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk         (clk),
    .rst         (rst),
    .en          (bus.en),
    .w           (bus.w),
    .add         (bus.add),
    .d_in        (bus.d_in),
    .busy        (busy),
    .in_range_c  (in_range_c),
    .mem_we_c    (mem_we_c),
    .mem_addr_c  (mem_addr_c),
    .mem_wdata_c (mem_wdata_c)
  );

  always_comb begin
`ifdef RAM_PARITY_EN
    wr_word_c = {parity_f(PAR_MAX_W'(mem_wdata_c)), mem_wdata_c};
`else
    wr_word_c = mem_wdata_c;
`endif
    // A same-cycle user write always targets bus.add, so forwarding needs no compare.
    rd_word_c = (WR_FWD && mem_we_c) ? wr_word_c : mem[bus.add];
    rd_req_c  = ~busy & bus.en & bus.r;
  end

  // Array has no reset; zero fill comes from the clear sequencer.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_addr_c] <= wr_word_c;
  end

`ifdef RAM_PARITY_EN
  logic par_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= 1'b0;
      if (rd_req_c && in_range_c)
        par_err_q <= parity_f(PAR_MAX_W'(rd_word_c[DATA_W-1:0])) != rd_word_c[DATA_W];
    end
  end

  assign bus.par_err = par_err_q;
`endif

  // Out-of-range reads still strobe valid but return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_out_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (rd_req_c) begin
        valid_q <= 1'b1;
        d_out_q <= in_range_c ? rd_word_c[DATA_W-1:0] : '0;
      end
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy;

endmodule
